gray_to_bin_arbiter: RTL and testbench

Shares one bit-serial Gray-to-binary conversion engine among NREQ requesters. A round-robin arbiter grants one requester at a time. The block captures that requester's Gray word and resolves it MSB-first, one bit per clock. It then presents the binary result and the requester ID on a valid/ready output port. It sits between Gray-coded sources (counters, position encoders) and binary consumers.

---
 rtl/gray_to_bin_arbiter_if.sv | 25 ++
 rtl/gray_to_bin_arbiter.sv | 127 ++++++++++++
 tb/tb_gray_to_bin_arbiter.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/gray_to_bin_arbiter_if.sv
// Request/result bundle for the shared Gray-to-binary engine.
// The slave side is the engine; the master side is the requesters and consumer.
interface gray_to_bin_arbiter_if #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4,
  parameter int ID_W  = 2
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_gray;
  logic [NREQ-1:0]       req_ready;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_bin;
  logic [ID_W-1:0]       out_id;

  modport master (
    output req_valid, req_gray, out_ready,
    input  req_ready, out_valid, out_bin, out_id
  );

  modport slave (
    input  req_valid, req_gray, out_ready,
    output req_ready, out_valid, out_bin, out_id
  );
endinterface

// File: rtl/gray_to_bin_arbiter.sv
// Round-robin shared bit-serial Gray-to-binary converter: grant one requester,
// resolve its word MSB-first one bit per clock, then hold the result until taken.
module gray_to_bin_arbiter #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4,
  parameter int ID_W  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  gray_to_bin_arbiter_if.slave   bus
);
  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [ID_W-1:0]  rr_ptr_r;
  logic [ID_W-1:0]  gnt_s;
  logic [ID_W-1:0]  idx_s;
  int               sum_s;
  logic             any_s;
  logic [NREQ-1:0]  gnt_onehot_s;
  logic [WIDTH-1:0] gray_sel_s;
  logic [WIDTH-1:0] gray_r;
  logic [WIDTH-1:0] bin_r;
  logic [WIDTH-1:0] above_s;
  logic [CNT_W-1:0] cnt_r;
  logic             out_valid_r;
  logic [ID_W-1:0]  out_id_r;

  // Round-robin search; walking offsets high-to-low lets the nearest one to rr_ptr win.
  always_comb begin
    gnt_s = '0;
    any_s = 1'b0;
    idx_s = '0;
    sum_s = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      sum_s = (int'(rr_ptr_r) + i >= NREQ) ? (int'(rr_ptr_r) + i - NREQ) : (int'(rr_ptr_r) + i);
      idx_s = ID_W'(sum_s);
      gnt_s = bus.req_valid[idx_s] ? idx_s : gnt_s;
      any_s = any_s | bus.req_valid[idx_s];
    end
  end

  // Granted requester's Gray word and one-hot grant vector.
  always_comb begin
    gray_sel_s   = '0;
    gnt_onehot_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      gray_sel_s      = (gnt_s == ID_W'(i)) ? bus.req_gray[i*WIDTH +: WIDTH] : gray_sel_s;
      gnt_onehot_s[i] = (gnt_s == ID_W'(i));
    end
  end

  // Bit k of the result is the already-resolved bit k+1 XOR gray[k]; the MSB sees a 0 above it.
  assign above_s = {1'b0, bin_r[WIDTH-1:1]};

  assign bus.req_ready = (!rst && state_r == IDLE && any_s) ? gnt_onehot_s : '0;
  assign bus.out_valid = out_valid_r;
  assign bus.out_bin   = bin_r;
  assign bus.out_id    = out_id_r;

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    state_nxt_s = any_s ? CONV : IDLE;
      CONV:    state_nxt_s = (cnt_r == '0) ? DONE : CONV;
      DONE:    state_nxt_s = bus.out_ready ? IDLE : DONE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Capture, serial conversion and result hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_r    <= '0;
      gray_r      <= '0;
      bin_r       <= '0;
      cnt_r       <= '0;
      out_valid_r <= 1'b0;
      out_id_r    <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (any_s) begin
            gray_r   <= gray_sel_s;
            bin_r    <= '0;
            out_id_r <= gnt_s;
            cnt_r    <= CNT_W'(WIDTH - 1);
            rr_ptr_r <= (gnt_s == ID_W'(NREQ - 1)) ? '0 : gnt_s + 1'b1;
          end
        end
        CONV: begin
          bin_r[cnt_r] <= above_s[cnt_r] ^ gray_r[cnt_r];
          if (cnt_r == '0) begin
            out_valid_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r - 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_gray_to_bin_arbiter.sv
// Directed bench for gray_to_bin_arbiter: reset, round-robin order, latency,
// backpressure, mid-conversion reset and all 16 Gray codes on one requester.
module tb_gray_to_bin_arbiter;
  localparam int WIDTH = 4;
  localparam int NREQ  = 4;
  localparam int ID_W  = 2;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  gray_to_bin_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ), .ID_W(ID_W)) bus ();

  gray_to_bin_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .ID_W(ID_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [3:0] gray;
    logic [3:0] bin;
  } conv_vec_t;

  typedef struct {
    logic [3:0] onehot;
    logic [1:0] id;
    logic [3:0] bin;
  } rr_vec_t;

  conv_vec_t conv_tab [16];
  rr_vec_t   rr_tab   [4];
  int        pass_cnt  = 0;
  int        total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a grant, accept it, drop that request, then time the result.
  task automatic serve(input string tag, input logic [3:0] exp_gnt,
                       input logic [1:0] exp_id, input logic [3:0] exp_bin);
    logic [3:0] seen;
    int n;
    #1;
    n = 0;
    while (bus.req_ready == 4'b0000 && n < 20) begin
      tick();
      n++;
    end
    seen = bus.req_ready;
    chk({tag, "_grant"}, 32'(seen), 32'(exp_gnt));
    tick();
    chk({tag, "_ready_pulse"}, 32'(bus.req_ready), 32'd0);
    bus.req_valid = bus.req_valid & ~seen;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'(WIDTH));
    chk({tag, "_bin"}, 32'(bus.out_bin), 32'(exp_bin));
    chk({tag, "_id"}, 32'(bus.out_id), 32'(exp_id));
  endtask

  initial begin
    logic ok;

    conv_tab[0]  = '{4'b0000, 4'b0000};
    conv_tab[1]  = '{4'b0001, 4'b0001};
    conv_tab[2]  = '{4'b0010, 4'b0011};
    conv_tab[3]  = '{4'b0011, 4'b0010};
    conv_tab[4]  = '{4'b0100, 4'b0111};
    conv_tab[5]  = '{4'b0101, 4'b0110};
    conv_tab[6]  = '{4'b0110, 4'b0100};
    conv_tab[7]  = '{4'b0111, 4'b0101};
    conv_tab[8]  = '{4'b1000, 4'b1111};
    conv_tab[9]  = '{4'b1001, 4'b1110};
    conv_tab[10] = '{4'b1010, 4'b1100};
    conv_tab[11] = '{4'b1011, 4'b1101};
    conv_tab[12] = '{4'b1100, 4'b1000};
    conv_tab[13] = '{4'b1101, 4'b1001};
    conv_tab[14] = '{4'b1110, 4'b1011};
    conv_tab[15] = '{4'b1111, 4'b1010};

    rr_tab[0] = '{4'b0001, 2'd0, 4'b0000};
    rr_tab[1] = '{4'b0010, 2'd1, 4'b0001};
    rr_tab[2] = '{4'b0100, 2'd2, 4'b0010};
    rr_tab[3] = '{4'b1000, 2'd3, 4'b0011};

    // Reset held with every request pending.
    rst           = 1'b1;
    bus.req_valid = 4'b1111;
    bus.req_gray  = {4'b0010, 4'b0011, 4'b0001, 4'b1101};
    bus.out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_bin", 32'(bus.out_bin), 32'd0);
      chk("rst_out_id", 32'(bus.out_id), 32'd0);
    end
    rst           = 1'b0;
    bus.out_ready = 1'b1;
    serve("t1", 4'b0001, 2'd0, 4'b1001);
    bus.req_valid = 4'b0001;
    tick();
    chk("t1_handshake", 32'(bus.out_valid), 32'd0);

    // Single request, Gray 1101 -> 1001.
    serve("t2", 4'b0001, 2'd0, 4'b1001);
    bus.req_valid = 4'b0000;
    tick();
    chk("t2_handshake", 32'(bus.out_valid), 32'd0);

    // Round robin from a fresh reset.
    rst = 1'b1;
    tick();
    rst           = 1'b0;
    bus.req_gray  = {4'b0010, 4'b0011, 4'b0001, 4'b0000};
    bus.req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      serve($sformatf("t3_rr%0d", i), rr_tab[i].onehot, rr_tab[i].id, rr_tab[i].bin);
      tick();
    end
    bus.req_valid = 4'b1111;
    serve("t3_restart", 4'b0001, 2'd0, 4'b0000);
    bus.req_valid = 4'b0000;
    tick();

    // Backpressure: result must hold while out_ready is low.
    bus.req_valid = 4'b1111;
    bus.out_ready = 1'b0;
    serve("t4", 4'b0010, 2'd1, 4'b0001);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("t4_hold_valid", 32'(bus.out_valid), 32'd1);
      chk("t4_hold_bin", 32'(bus.out_bin), 32'(4'b0001));
      chk("t4_hold_id", 32'(bus.out_id), 32'd1);
      chk("t4_hold_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    tick();
    chk("t4_handshake", 32'(bus.out_valid), 32'd0);
    chk("t4_idle_grant", 32'(bus.req_ready), 32'(4'b0100));
    tick();
    chk("t4_next_conv", 32'(bus.req_ready), 32'd0);
    bus.req_valid = 4'b0000;
    for (int c = 0; c < WIDTH + 3; c++) tick();

    // Reset in the second conversion cycle discards the word and clears rr_ptr.
    bus.req_gray[11:8] = 4'b1111;
    bus.req_valid      = 4'b0100;
    #1;
    chk("t5_grant", 32'(bus.req_ready), 32'(4'b0100));
    tick();
    bus.req_valid = 4'b0000;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_valid_after_rst", 32'(bus.out_valid), 32'd0);
    chk("t5_bin_after_rst", 32'(bus.out_bin), 32'd0);
    chk("t5_id_after_rst", 32'(bus.out_id), 32'd0);
    ok = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (bus.out_valid) ok = 1'b0;
    end
    chk("t5_no_stale_valid", 32'(ok), 32'd1);
    bus.req_valid = 4'b1010;
    #1;
    chk("t5_rr_after_rst", 32'(bus.req_ready), 32'(4'b0010));
    serve("t5_after", 4'b0010, 2'd1, 4'b0001);
    bus.req_valid = 4'b0000;
    tick();

    // Requester 2 alone through every Gray code.
    for (int i = 0; i < 16; i++) begin
      bus.req_gray[11:8] = conv_tab[i].gray;
      bus.req_valid      = 4'b0100;
      serve($sformatf("t6_g%0d", i), 4'b0100, 2'd2, conv_tab[i].bin);
      tick();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
